// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a req/ack backing-memory port.
// Define DCACHE_STATS_EN to add read hit/miss counters (hit_cnt, miss_cnt).
module dcache_dm #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r_en,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        state_dbg,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  // Backing-memory handshake: mem_req rises with mem_we/mem_addr/mem_wdata stable and
  // stays high until the cycle mem_ack=1 is sampled; the request drops on the next edge.
  // mem_ack sampled while mem_req=0 has no effect.

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 2 ** INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [INDEX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               hit;
  logic               rd_hit, rd_miss, wr_start, fill_done, wr_done;

  assign req_idx   = addr[INDEX_W-1:0];
  assign req_tag   = addr[ADDR_W-1:INDEX_W];
  assign fill_idx  = mem_addr[INDEX_W-1:0];
  assign fill_tag  = mem_addr[ADDR_W-1:INDEX_W];
  assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign state_dbg = state_q;

  // A simultaneous read+write is serviced as a write only.
  always_comb begin
    state_d   = state_q;
    rd_hit    = 1'b0;
    rd_miss   = 1'b0;
    wr_start  = 1'b0;
    fill_done = 1'b0;
    wr_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!busy && (r_en || w_en)) begin
          if (w_en) begin
            wr_start = 1'b1;
            state_d  = WRITE;
          end else if (hit) begin
            rd_hit = 1'b1;
          end else begin
            rd_miss = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          wr_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      r_valid <= 1'b0;
      if (rd_hit) begin
        r_data  <= data_mem[req_idx];
        r_valid <= 1'b1;
      end
      if (rd_miss || wr_start) begin
        busy     <= 1'b1;
        mem_req  <= 1'b1;
        mem_we   <= wr_start;
        mem_addr <= addr;
        if (wr_start) mem_wdata <= w_data;
      end
      if (fill_done) begin
        valid_q[fill_idx] <= 1'b1;
        r_data            <= mem_rdata;
        r_valid           <= 1'b1;
      end
      if (fill_done || wr_done) begin
        busy    <= 1'b0;
        mem_req <= 1'b0;
      end
    end
  end

  // Tag/data arrays carry no reset so they can map onto RAM; valid_q guards them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_start && hit) data_mem[req_idx] <= w_data;
      if (fill_done) begin
        tag_mem[fill_idx]  <= fill_tag;
        data_mem[fill_idx] <= mem_rdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (rd_hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (rd_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
Parametrised direct-mapped, write-through, no-write-allocate data cache. It replaces the flat 256-word data memory between the core load/store stage and the backing data memory. Read hits return data in 1 cycle. Misses and all writes go to the backing memory over a req/ack handshake, and the cache reports busy to the core while that transaction is outstanding.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 16, word address width
INDEX_W, 8, index bits; the cache holds 2**INDEX_W one-word lines (tag width = ADDR_W-INDEX_W)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
r_en  input  1  core read request
w_en  input  1  core write request
addr  input  ADDR_W  core word address
w_data  input  DATA_W  core write data
r_data  output  DATA_W  read data, held until the next read completes
r_valid  output  1  1-cycle pulse: r_data updated
busy  output  1  cache is servicing a miss or write; new requests are ignored
mem_req  output  1  backing-memory request, held until mem_ack
mem_we  output  1  1 = write, 0 = read (fill)
mem_addr  output  ADDR_W  backing-memory word address
mem_wdata  output  DATA_W  backing-memory write data
mem_ack  input  1  backing memory done; mem_rdata valid in the same cycle for reads
mem_rdata  input  DATA_W  fill data

Behaviour:
- Reset (clk edge with reset=1): all line valid bits cleared; state=IDLE; r_data=0, r_valid=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Tag/data arrays are not cleared. Reset mid-transaction drops mem_req on the next cycle and abandons the transaction with no core response.
- Request acceptance: a request is accepted in cycle N when state=IDLE, busy=0, and r_en|w_en=1.
  - If r_en and w_en are both 1, the request is treated as a write only.
  - Requests while busy=1 are dropped silently; the core must re-issue them.
- Index/tag split: index=addr[INDEX_W-1:0], tag=addr[ADDR_W-1:INDEX_W].
- Hit: valid[index]=1 and tag_mem[index]==tag.
- States: IDLE, FILL, WRITE.
- Read hit (accepted cycle N):
  - r_data=data_mem[index] and r_valid=1 at N+1.
  - State stays IDLE, busy stays 0, so back-to-back hits run at 1 per cycle.
- Read miss (accepted cycle N):
  - At N+1: state=FILL, busy=1, mem_req=1, mem_we=0, mem_addr=addr latched at N.
  - On the cycle M where mem_ack=1: tag/data/valid for the line are written with mem_rdata.
  - At M+1: r_data=mem_rdata, r_valid=1, mem_req=0, busy=0, state=IDLE.
  - Minimum miss latency is 2 cycles (ack in the first FILL cycle).
- Write (accepted cycle N):
  - If hit, data_mem[index] is updated at the N edge. A miss allocates nothing.
  - At N+1: state=WRITE, busy=1, mem_req=1, mem_we=1, mem_addr/mem_wdata latched.
  - Ack at M: at M+1 mem_req=0, busy=0, state=IDLE.
  - r_data is unchanged; r_valid=0.
- mem_addr/mem_we/mem_wdata stay stable while mem_req=1. mem_ack while mem_req=0 is ignored.
- A fill overwrites any valid line at the same index (eviction needs no writeback because the cache is write-through).
- busy and all outputs are registered. No combinational path exists from mem_ack to core outputs.

Optional Feature:
DCACHE_STATS_EN:
- When defined, adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on every accepted read hit.
  - miss_cnt increments on every accepted read miss.
  - Both are cleared by reset and wrap at 2**32 with no saturation.
  - Writes are not counted.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, then read addr 0x0012 with mem_rdata=0xBEEF, ack on the 3rd FILL cycle -> busy=1 for 3 cycles, mem_addr=0x0012, r_data=0xBEEF with r_valid pulse, busy=0 afterwards.
- Read 0x0012 again -> r_data=0xBEEF and r_valid at N+1, mem_req stays 0, busy stays 0.
- Write 0x1234 to 0x0012 (hit), ack next cycle -> mem_we=1, mem_wdata=0x1234; a following read of 0x0012 hits with r_data=0x1234 and no mem_req.
- Read 0x0112 (same index, different tag) -> miss, fill with 0x5555 evicts the line; a following read of 0x0012 misses again.
- r_en=w_en=1 at 0x0020, then r_en=1 issued while busy=1 -> only a write transaction appears; the read is dropped (no r_valid).
- Assert reset during FILL -> mem_req=0 next cycle, no r_valid, and a read of a previously cached address misses. With DCACHE_STATS_EN, counters read 0 after reset, and 2 misses plus 1 hit give miss_cnt=2, hit_cnt=1.
